// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode prefetch FIFO of {pc, inst} pairs with flush.
// Optional same-cycle cut-through when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       mem_q [DEPTH];
    logic [63:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              has_data;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [63:0]       head;

    always_comb begin
        has_data = (count_q != '0);
        bypass   = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        bypass   = !has_data && in_valid && out_ready && !flush;
`else
        bypass   = 1'b0;
`endif
        head      = mem_q[rd_ptr_q];
        in_ready  = (count_q != FULL_CNT);
        out_valid = has_data || bypass;
        out_pc    = '0;
        out_inst  = '0;
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else if (has_data) begin
            out_pc   = head[63:32];
            out_inst = head[31:0];
        end
        // A bypassed pair is consumed directly, so it must not also be stored.
        push  = in_valid && in_ready && !flush && !bypass;
        pop   = has_data && out_ready && !flush;
        count = count_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_pc, in_inst};
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (ADDR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction prefetch queue between the instruction fetch stage (PC register plus instruction ROM) and the decode stage.
- Buffers up to DEPTH fetched {pc, inst} pairs.
- Fetch and decode exchange pairs over a valid/ready handshake, so a decode stall does not lose fetched instructions.
- Synchronous flush empties the queue on branch redirect.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low; queue empty while low
flush  input  1  synchronous flush; empties queue at next edge
in_valid  input  1  fetch presents a valid pc/inst pair
in_ready  output  1  queue can accept a pair this cycle
in_pc  input  32  address of fetched instruction
in_inst  input  32  fetched instruction word
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts head entry this cycle
out_pc  output  32  pc of head entry
out_inst  output  32  instruction of head entry
count  output  ADDR_W+1  number of occupied entries, 0..DEPTH

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, all storage cleared to 0.
  - Outputs: out_valid=0, out_pc=0, out_inst=0, in_ready=1.
  - Reset asserted mid-operation discards all entries immediately; no partial state survives.
- Handshake signals:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
  - in_ready = (count != DEPTH). It does not depend on out_ready, so a full queue refuses input even while popping.
  - out_valid = (count != 0).
  - out_pc/out_inst = storage[rd_ptr] when out_valid=1, else 0.
- Pointer updates:
  - push: storage[wr_ptr] <= {in_pc, in_inst}; wr_ptr increments, wrapping DEPTH-1 -> 0.
  - pop: rd_ptr increments with the same wrap.
- count update: push only +1; pop only -1; push and pop together leaves count unchanged; neither leaves it unchanged.
- Latency: an entry pushed at edge N is visible on out_* during cycle N+1. Minimum fetch-to-decode latency is 1 cycle.
- Ordering: strict FIFO. Entries leave in push order, unmodified.
- Full (count=DEPTH): in_ready=0; in_valid is ignored, and fetch must hold its data.
- Empty (count=0): out_valid=0; out_ready is ignored, and no pointer moves.
- flush:
  - At the next edge, count=0 and wr_ptr=rd_ptr=0. Storage contents are don't-care.
  - Flush overrides push and pop in the same cycle: the incoming pair is dropped, and out_* still shows the old head during the flush cycle.
- Overflow and underflow are impossible by construction; no error output.
- All outputs come from registered state plus a combinational read mux. There is no in_* -> out_* combinational path.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined (cut-through):
  - Condition: count=0, in_valid=1, out_ready=1, flush=0.
  - Result: out_valid=1, out_pc=in_pc, out_inst=in_inst in the same cycle. The pair is consumed without being written; pointers and count are unchanged.
  - If out_ready=0, normal enqueue occurs.
  - This adds a combinational in_* -> out_* path.
- Not defined: behaviour exactly as above; minimum latency 1 cycle.

Test Plan:
- Reset/order: release rst at 195 ns. Push pc=0x0,0x4,0x8 with inst=0x11111111,0x22222222,0x33333333 while out_ready=0. Expect count=3, out_pc=0x0. Then set out_ready=1: three pops in order 0x0,0x4,0x8, then out_valid=0, count=0.
- Full/wrap:
  - Push 4 entries (pc 0x0..0xC) with out_ready=0: count=4, in_ready=0.
  - A fifth in_valid with pc=0x10 is not accepted.
  - Pop one, push 0x10: wr_ptr wraps to 1; the pop sequence is 0x4,0x8,0xC,0x10.
- Simultaneous: count=2, in_valid=1, out_ready=1 for 5 cycles with pc 0x20..0x30. count stays 2 every cycle; outputs match push order 2 cycles later.
- Flush:
  - With count=3, assert flush for one cycle with in_valid=1, out_ready=1.
  - Next cycle: count=0, out_valid=0, and the flush-cycle input is absent.
  - A subsequent push of pc=0x100 appears as the next head.
- Async reset mid-operation: with count=2, pull rst low between clock edges. out_valid=0 and count=0 immediately, without waiting for a clock edge.
- Bypass (INST_QUEUE_BYPASS_EN defined): empty queue, in_valid=1, out_ready=1, in_pc=0x40. out_valid=1 and out_pc=0x40 in the same cycle; count stays 0. Without the macro, out_valid rises one cycle later and count pulses to 1.
